// File: rtl/ripplesub4_clk.sv
// Four-stage pipelined ripple subtractor: stage k resolves difference bit k from the
// borrow registered by stage k-1, with operand skew and result deskew registers.
module ripplesub4_clk (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] diff,
    output logic       bout,
    output logic       out_valid,
    input  logic       out_ready
);

    // Stage valid bits and registered borrow-out of each stage.
    logic [3:0] vld;
    logic [3:0] brw;

    // Operand skew: only the bits still to be resolved travel forward.
    logic [3:1] a_s0, b_s0;
    logic [3:2] a_s1, b_s1;
    logic       a_s2, b_s2;

    // Result deskew: resolved difference bits accumulate until they leave S3.
    logic       d_s0;
    logic [1:0] d_s1;
    logic [2:0] d_s2;
    logic [3:0] d_s3;

    logic       advance;
    logic [1:0] r0, r1, r2, r3;

    // One-bit full subtractor, returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
    endfunction

    assign advance  = !vld[3] || out_ready;
    assign in_ready = advance;

    assign r0 = full_sub(a[0],    b[0],    bin);
    assign r1 = full_sub(a_s0[1], b_s0[1], brw[0]);
    assign r2 = full_sub(a_s1[2], b_s1[2], brw[1]);
    assign r3 = full_sub(a_s2,    b_s2,    brw[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, not only the valid bits, so a
            // reset leaves no stale operand or borrow state anywhere in the pipeline.
            vld  <= '0;
            brw  <= '0;
            a_s0 <= '0;
            b_s0 <= '0;
            a_s1 <= '0;
            b_s1 <= '0;
            a_s2 <= 1'b0;
            b_s2 <= 1'b0;
            d_s0 <= 1'b0;
            d_s1 <= '0;
            d_s2 <= '0;
            d_s3 <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments make every stage load its predecessor's
            // pre-edge value; blocking ones would let data fall through several stages.
            vld  <= {vld[2:0], in_valid};
            brw  <= {r3[1], r2[1], r1[1], r0[1]};
            a_s0 <= a[3:1];
            b_s0 <= b[3:1];
            a_s1 <= a_s0[3:2];
            b_s1 <= b_s0[3:2];
            a_s2 <= a_s1[3];
            b_s2 <= b_s1[3];
            d_s0 <= r0[0];
            d_s1 <= {r1[0], d_s0};
            d_s2 <= {r2[0], d_s1};
            d_s3 <= {r3[0], d_s2};
        end
    end

    assign out_valid = vld[3];
    assign diff      = vld[3] ? d_s3 : 4'b0000;
    assign bout      = vld[3] & brw[3];

endmodule
